// File: rtl/rv32im_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   op_e    : funct3 encodings of the M-extension operations
//   state_e : sequencer states of the iterative unit
//   INT_MIN, ALL_ONES : architectural constants for the special-case results
//   a_signed / b_signed : whether each operand is interpreted as signed for an op
package rv32im_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  function automatic logic a_signed(op_e op);
    return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic b_signed(op_e op);
    return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/rv32im_muldiv_unit_if.sv
// Request/response bundle between the EX stage (master) and the muldiv unit (slave).
//   flush       : EX -> unit, abort the in-flight operation
//   req_*       : valid/ready request carrying funct3 and the two operands
//   resp_*      : valid/ready response carrying the result
//   busy        : unit -> EX, high whenever the unit is not idle
interface rv32im_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            flush;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic            busy;

  modport master (
    output flush, req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, busy
  );

  modport slave (
    input  flush, req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, busy
  );

endinterface

// File: rtl/rv32im_muldiv_unit.sv
// Iterative RV32M execution unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Operands are reduced to magnitudes on acceptance; a single 2*XLEN accumulator is
// then used either as {partial product, multiplier} (shift-add, shifting right) or as
// {partial remainder, dividend/quotient} (restoring divide, shifting left). Signs are
// re-applied in the FIX state. Divide-by-zero and signed overflow bypass the iteration.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of rv32im_muldiv_unit_if (request, response, flush, busy)
module rv32im_muldiv_unit
  import rv32im_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rv32im_muldiv_unit_if.slave   bus
);

  localparam int unsigned N    = XLEN / STEPS_PER_CYCLE;
  localparam int unsigned CntW = $clog2(N);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;
  logic [XLEN-1:0]     divisor_q, divisor_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Request decode
  op_e             op_in;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_result;
  logic            accept;

  always_comb begin
    op_in    = op_e'(bus.req_op);
    a_neg    = a_signed(op_in) && bus.req_a[XLEN-1];
    b_neg    = b_signed(op_in) && bus.req_b[XLEN-1];
    a_mag    = a_neg ? -bus.req_a : bus.req_a;
    b_mag    = b_neg ? -bus.req_b : bus.req_b;
    div_zero = bus.req_op[2] && (bus.req_b == '0);
    div_ovf  = ((op_in == OpDiv) || (op_in == OpRem)) &&
               (bus.req_a == INT_MIN) && (bus.req_b == ALL_ONES);
    // funct3[1] selects remainder among the divide ops
    if (div_zero) begin
      special_result = bus.req_op[1] ? bus.req_a : ALL_ONES;
    end else begin
      special_result = bus.req_op[1] ? '0 : INT_MIN;
    end
    // flush has priority over acceptance
    accept = bus.req_valid && (state_q == StIdle) && !bus.flush;
  end

  // One clock's worth of iterations on the shared accumulator
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;
    acc_step = acc_q;
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
      if (!op_q[2]) begin
        // Multiply: add multiplicand into the upper half when the LSB of the
        // multiplier is set, then shift the whole product right by one.
        sum      = {1'b0, acc_step[2*XLEN-1:XLEN]} + (acc_step[0] ? {1'b0, divisor_q} : '0);
        acc_step = {sum, acc_step[XLEN-1:1]};
      end else begin
        // Restoring divide: shift the next dividend bit into the remainder and
        // keep the subtraction only when it does not go negative.
        rem_sh = acc_step[2*XLEN-1:XLEN-1];
        diff   = rem_sh - {1'b0, divisor_q};
        if (!diff[XLEN]) begin
          acc_step = {diff[XLEN-1:0], acc_step[XLEN-2:0], 1'b1};
        end else begin
          acc_step = {rem_sh[XLEN-1:0], acc_step[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  // Sign correction and result select
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   fix_result;

  always_comb begin
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quot = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      OpMul:                      fix_result = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu:  fix_result = prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:              fix_result = quot;
      OpRem, OpRemu:              fix_result = rem;
      default:                    fix_result = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    divisor_d = divisor_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    if (bus.flush && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_d      = op_in;
            sa_d      = a_neg;
            sb_d      = b_neg;
            divisor_d = b_mag;
            acc_d     = {{XLEN{1'b0}}, a_mag};
            cnt_d     = '0;
            if (div_zero || div_ovf) begin
              result_d = special_result;
              state_d  = StDone;
            end else begin
              state_d  = StCalc;
            end
          end
        end
        StCalc: begin
          acc_d = acc_step;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(N - 1)) begin
            state_d = StFix;
          end
        end
        StFix: begin
          result_d = fix_result;
          state_d  = StDone;
        end
        StDone: begin
          if (bus.resp_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= OpMul;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      divisor_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      divisor_q <= divisor_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign bus.req_ready   = (state_q == StIdle);
  assign bus.resp_valid  = (state_q == StDone);
  assign bus.busy        = (state_q != StIdle);
  assign bus.resp_result = result_q;

endmodule

// File: tb/tb_rv32im_muldiv_unit.sv
// Self-checking bench for rv32im_muldiv_unit (XLEN=32, STEPS_PER_CYCLE=1).
// Expected results are pushed to a queue at acceptance and popped when the
// response is taken. done_edge is the clock edge (accepting edge = 0) on which
// the unit enters DONE: 33 for iterated ops, 0 for special cases.
module tb_rv32im_muldiv_unit;

  logic clk;
  logic rst_n;

  rv32im_muldiv_unit_if #(.XLEN(32)) bus ();

  rv32im_muldiv_unit #(
    .XLEN            (32),
    .STEPS_PER_CYCLE (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          done_edge;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Present a request, let it be accepted, push its expected result.
  task automatic start_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    check({name, " req_ready before issue"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    exp_q.push_back(exp);
    #1 bus.req_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge; counts edges until resp_valid.
  task automatic wait_done(input string name, input int done_edge);
    int lat;
    lat = 0;
    while (!bus.resp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " done edge"}, lat, done_edge);
    check({name, " req_ready in DONE"}, {31'd0, bus.req_ready}, 32'd0);
  endtask

  task automatic take_resp(input string name);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      exp = 32'hDEAD_BEEF;
      $display("FAIL %s: scoreboard empty, got %h required none", name, bus.resp_result);
      checks++;
      errors++;
    end else begin
      exp = exp_q.pop_front();
      check({name, " result"}, bus.resp_result, exp);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    check({name, " resp_valid after take"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  task automatic do_op(input vec_t v);
    start_op(v.name, v.op, v.a, v.b, v.exp);
    wait_done(v.name, v.done_edge);
    take_resp(v.name);
  endtask

  initial begin
    logic        ok;
    logic [31:0] held;

    vecs.push_back('{"mul 7x-3",        3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{"mulh min*min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
    vecs.push_back('{"mulhu max*max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{"mulhsu -1*2",     3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{"mulh -1*-1",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33});
    vecs.push_back('{"mul ffff*ffff",   3'b000, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 33});
    vecs.push_back('{"div -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{"rem -7/2",        3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{"divu fffffffe/2", 3'b101, 32'hFFFF_FFFE, 32'd2,         32'h7FFF_FFFF, 33});
    vecs.push_back('{"remu 100/7",      3'b111, 32'd100,       32'd7,         32'd2,         33});
    vecs.push_back('{"div 20/-3",       3'b100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33});
    vecs.push_back('{"rem 20/-3",       3'b110, 32'd20,        32'hFFFF_FFFD, 32'd2,         33});
    vecs.push_back('{"divu min/max",    3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33});
    vecs.push_back('{"div 5/0",         3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 0});
    vecs.push_back('{"rem 5/0",         3'b110, 32'd5,         32'd0,         32'd5,         0});
    vecs.push_back('{"remu x/0",        3'b111, 32'h1234_5678, 32'd0,         32'h1234_5678, 0});
    vecs.push_back('{"div ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0});
    vecs.push_back('{"rem ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0});

    rst_n          = 1'b0;
    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'b000;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset resp_valid",  {31'd0, bus.resp_valid}, 32'd0);
    check("reset req_ready",   {31'd0, bus.req_ready},  32'd1);
    check("reset busy",        {31'd0, bus.busy},       32'd0);
    check("reset resp_result", bus.resp_result,         32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) do_op(vecs[i]);

    // Backpressure: hold the result, request waiting, then one bubble
    start_op("bp", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    wait_done("bp", 33);
    held = bus.resp_result;
    ok   = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (!bus.resp_valid || bus.req_ready || bus.resp_result !== held) ok = 1'b0;
    end
    check("bp stable 5 cycles", {31'd0, ok}, 32'd1);
    check("bp result", bus.resp_result, exp_q.pop_front());
    @(negedge clk);
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_op     = 3'b000;
    bus.req_a      = 32'd3;
    bus.req_b      = 32'd5;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    check("bp back to idle", {31'd0, bus.busy}, 32'd0);
    check("bp resp_valid fell", {31'd0, bus.resp_valid}, 32'd0);
    @(posedge clk);
    exp_q.push_back(32'd15);
    #1 bus.req_valid = 1'b0;
    check("bp accepted after bubble", {31'd0, bus.busy}, 32'd1);
    wait_done("bp next", 33);
    take_resp("bp next");

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    check("idle flush blocks accept", {31'd0, bus.busy}, 32'd0);

    // Flush 10 cycles into a DIV
    start_op("flush div", 3'b100, 32'd100, 32'd7, 32'd14);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    void'(exp_q.pop_front());
    check("flush req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("flush busy", {31'd0, bus.busy}, 32'd0);
    ok = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) ok = 1'b0;
    end
    check("flush no response", {31'd0, ok}, 32'd1);
    do_op('{"mul 3x4 after flush", 3'b000, 32'd3, 32'd4, 32'd12, 33});

    // Reset mid-CALC
    start_op("rst div", 3'b101, 32'd1000, 32'd3, 32'd333);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("rst resp_valid",  {31'd0, bus.resp_valid}, 32'd0);
    check("rst req_ready",   {31'd0, bus.req_ready},  32'd1);
    check("rst busy",        {31'd0, bus.busy},       32'd0);
    check("rst resp_result", bus.resp_result,         32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op('{"remu after reset", 3'b111, 32'd100, 32'd7, 32'd2, 33});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end required end of test");
    $fatal(1, "timeout");
  end

endmodule
